// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 Pmod OLED SPI transmitter.
package oled_pkg;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } oled_state_e;

  // D/C# levels: low selects the command register, high selects display RAM.
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // SPI mode 3 keeps SCLK high between bytes.
  localparam logic SCLK_IDLE = 1'b1;

  // The half-period divider only runs while a byte is on the wire.
  function automatic logic div_active(input oled_state_e st);
    return (st == ST_SETUP) || (st == ST_SHIFT) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/oled_clk_tick.sv
// Half-period tick generator: pulses for one cycle every CLK_DIV enabled
// cycles and restarts from zero whenever the enable is low.
module oled_clk_tick #(
  parameter int CLK_DIV = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // The tick marks the last cycle of a half-period.
  assign tick = en && (cnt_r == CNT_LAST);

  // Divider counter: wraps on the tick, held at zero while disabled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/oled_spi_tx.sv
// Byte-level SPI mode 3 transmitter for the SSD1306 Pmod OLED. One byte is
// accepted on the valid/done handshake and shifted out MSB first; SCLK falls
// to launch each bit and rises at the panel's sample point.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_is_data,
  input  logic       tx_valid,
  output logic       tx_done,
  output logic       busy,
  output logic       oled_spi_clk,
  output logic       oled_spi_data,
  output logic       oled_cs_n,
  output logic       oled_dc_n
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("oled_spi_tx: CLK_DIV must be at least 1");
  end

  oled_state_e state_r;
  oled_state_e state_s;

  logic [7:0] shreg_r;
  logic [3:0] edge_cnt_r;
  logic       sclk_r;
  logic       mosi_r;
  logic       cs_n_r;
  logic       dc_n_r;
  logic       done_r;
  logic       busy_r;

  logic       tick_s;
  logic       accept_s;

  oled_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .en    (div_active(state_r)),
    .tick  (tick_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and the acceptance strobe.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_valid && !done_r) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        // The 16th edge is the 8th rising edge, i.e. the last sample point.
        if (tick_s && (edge_cnt_r == 4'd15)) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (tick_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        // Leave only once done has been shown and the request has dropped.
        if (done_r && !tx_valid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and pin registers: shift register, edge counter, SPI pins, handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg_r    <= 8'h00;
      edge_cnt_r <= 4'd0;
      sclk_r     <= SCLK_IDLE;
      mosi_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      dc_n_r     <= DC_CMD;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shreg_r <= tx_data;
            dc_n_r  <= tx_is_data ? DC_DATA : DC_CMD;
            cs_n_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tick_s) begin
            sclk_r     <= ~sclk_r;
            edge_cnt_r <= edge_cnt_r + 4'd1;
            // SCLK currently high means this edge falls: launch the next bit.
            if (sclk_r) begin
              mosi_r  <= shreg_r[7];
              shreg_r <= {shreg_r[6:0], 1'b0};
            end
          end
        end
        ST_HOLD: begin
          if (tick_s) begin
            cs_n_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!done_r) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else if (!tx_valid) begin
            done_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tx_done       = done_r;
  assign busy          = busy_r;
  assign oled_spi_clk  = sclk_r;
  assign oled_spi_data = mosi_r;
  assign oled_cs_n     = cs_n_r;
  assign oled_dc_n     = dc_n_r;

endmodule
